// File: rtl/cache_arbiter_rr_pkg.sv
// Shared types for the L1-to-downstream cache arbiter.
// Holds the LC-3b word and line types and the arbiter state encoding.
package cache_arbiter_rr_pkg;

    localparam int LC3B_WORD_WIDTH = 16;
    localparam int LC3B_LINE_WIDTH = 128;

    typedef logic [LC3B_WORD_WIDTH-1:0] lc3b_word;
    typedef logic [LC3B_LINE_WIDTH-1:0] lc3b_l1_line;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/cache_arbiter_rr_picker.sv
// Combinational winner selection for the cache arbiter.
// Default: round robin, search starts at ptr and wraps.
// With ARB_FIXED_PRIORITY_EN defined: lowest active index wins and ptr is ignored.
module rr_priority_picker #(
    parameter int NUM_PORTS = 2,
    parameter int PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] active,
    input  logic [PW-1:0]        ptr,
    output logic [NUM_PORTS-1:0] grant_oh,
    output logic [PW-1:0]        grant_idx,
    output logic                 any_valid
);

    // Pick the first active port in search order, then form the one-hot grant.
    always_comb begin
        int  k;
        logic found;
        grant_oh  = '0;
        grant_idx = '0;
        any_valid = |active;
        k         = 0;
        found     = 1'b0;
`ifdef ARB_FIXED_PRIORITY_EN
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!found && active[i]) begin
                found     = 1'b1;
                grant_idx = PW'(i);
            end
        end
`else
        for (int i = 0; i < NUM_PORTS; i++) begin
            k = (int'(ptr) + i) % NUM_PORTS;
            if (!found && active[k]) begin
                found     = 1'b1;
                grant_idx = PW'(k);
            end
        end
`endif
        if (found) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/cache_arbiter_rr.sv
// N-port arbiter between L1 caches and one line-granular downstream memory.
// One downstream transaction at a time; the winner's request is captured into
// registers and the response is returned to it with a one-cycle req_resp pulse.
// Optional macro ARB_FIXED_PRIORITY_EN: fixed priority (lowest index wins), no RR pointer.
//
// state | meaning
// IDLE  | no transaction; pick a winner among active ports
// BUSY  | downstream strobe held from the latched op until mem_resp
// DONE  | req_resp pulse to the granted port, req_rdata valid
module cache_arbiter_rr
    import cache_arbiter_rr_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = LC3B_WORD_WIDTH,
    parameter int LINE_WIDTH = LC3B_LINE_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_PORTS-1:0]                 req_read,
    input  logic [NUM_PORTS-1:0]                 req_write,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] req_address,
    input  logic [NUM_PORTS-1:0][LINE_WIDTH-1:0] req_wdata,
    output logic [LINE_WIDTH-1:0]                req_rdata,
    output logic [NUM_PORTS-1:0]                 req_resp,
    output logic                                 mem_read,
    output logic                                 mem_write,
    output logic [ADDR_WIDTH-1:0]                mem_address,
    output logic [LINE_WIDTH-1:0]                mem_wdata,
    input  logic                                 mem_resp,
    input  logic [LINE_WIDTH-1:0]                mem_rdata
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    arb_state_t           state_q, state_d;
    logic [PW-1:0]        grant_q;
    logic [PW-1:0]        ptr_q;
    logic                 op_write_q;
    logic [NUM_PORTS-1:0] active;
    logic [NUM_PORTS-1:0] pick_oh;
    logic [PW-1:0]        pick_idx;
    logic                 any_valid;
    logic                 take;

    assign active = req_read | req_write;
    assign take   = (state_q == IDLE) && any_valid;

    rr_priority_picker #(
        .NUM_PORTS (NUM_PORTS),
        .PW        (PW)
    ) u_picker (
        .active    (active),
        .ptr       (ptr_q),
        .grant_oh  (pick_oh),
        .grant_idx (pick_idx),
        .any_valid (any_valid)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and strobe/response decode; strobes drop as soon as BUSY is left.
    always_comb begin
        state_d   = state_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        req_resp  = '0;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                mem_read  = ~op_write_q;
                mem_write = op_write_q;
                if (mem_resp) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                req_resp[grant_q] = 1'b1;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture the winner's request; latch read data on a read completion only.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q     <= '0;
            op_write_q  <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            req_rdata   <= '0;
        end else begin
            if (take) begin
                grant_q     <= pick_idx;
                op_write_q  <= |(req_write & pick_oh);
                mem_address <= req_address[pick_idx];
                mem_wdata   <= req_wdata[pick_idx];
            end
            if ((state_q == BUSY) && mem_resp && !op_write_q) begin
                req_rdata <= mem_rdata;
            end
        end
    end

`ifdef ARB_FIXED_PRIORITY_EN
    assign ptr_q = '0;
`else
    // Round-robin pointer moves to the port after the one just granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (take) begin
            ptr_q <= (pick_idx == PW'(NUM_PORTS - 1)) ? '0 : pick_idx + PW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_cache_arbiter_rr.sv
// Directed bench for cache_arbiter_rr with four ports.
module tb_cache_arbiter_rr;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int LW = 128;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N-1:0]          req_read;
    logic [N-1:0]          req_write;
    logic [N-1:0][AW-1:0]  req_address;
    logic [N-1:0][LW-1:0]  req_wdata;
    logic [LW-1:0]         req_rdata;
    logic [N-1:0]          req_resp;
    logic                  mem_read;
    logic                  mem_write;
    logic [AW-1:0]         mem_address;
    logic [LW-1:0]         mem_wdata;
    logic                  mem_resp;
    logic [LW-1:0]         mem_rdata;

    int n_total = 0;
    int n_bad   = 0;

    cache_arbiter_rr #(
        .NUM_PORTS  (N),
        .ADDR_WIDTH (AW),
        .LINE_WIDTH (LW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_read    (req_read),
        .req_write   (req_write),
        .req_address (req_address),
        .req_wdata   (req_wdata),
        .req_rdata   (req_rdata),
        .req_resp    (req_resp),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_resp    (mem_resp),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for the strobe, check the captured request, hold for 'hold' cycles,
    // answer with rdata, then check the DONE cycle.
    // mode 0: keep request up; 1: drop it on req_resp; 2: drop and scramble it once BUSY.
    task automatic serve(input string tag, input int port, input bit wr,
                         input logic [AW-1:0] addr, input logic [LW-1:0] wdata,
                         input logic [LW-1:0] rdata, input logic [LW-1:0] exp_rdata,
                         input int hold, input int mode);
        int  n;
        bit  stable;
        n = 0;
        while (!(mem_read || mem_write) && n < 10) begin
            tick();
            n++;
        end
        if (!(mem_read || mem_write)) begin
            chk({tag, "_timeout"}, 0, 1);
            return;
        end
        chk({tag, "_op"}, {mem_write, mem_read}, wr ? 2'b10 : 2'b01);
        chk({tag, "_addr"}, mem_address, addr);
        if (wr) chk({tag, "_wdata"}, mem_wdata, wdata);
        if (mode == 2) begin
            req_read[port]    = 1'b0;
            req_write[port]   = 1'b0;
            req_address[port] = ~addr;
            req_wdata[port]   = ~wdata;
        end
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            if ({mem_write, mem_read} !== (wr ? 2'b10 : 2'b01)) stable = 1'b0;
            if (mem_address !== addr) stable = 1'b0;
            if (wr && mem_wdata !== wdata) stable = 1'b0;
            if (req_resp !== '0) stable = 1'b0;
        end
        chk({tag, "_held"}, stable, 1'b1);
        mem_resp  = 1'b1;
        mem_rdata = rdata;
        tick();
        mem_resp  = 1'b0;
        mem_rdata = {4{$urandom()}};
        chk({tag, "_resp"}, req_resp, N'(1) << port);
        chk({tag, "_rdata"}, req_rdata, exp_rdata);
        chk({tag, "_strobe_off"}, {mem_write, mem_read}, 2'b00);
        if (mode == 1) begin
            req_read[port]  = 1'b0;
            req_write[port] = 1'b0;
        end
        tick();
        chk({tag, "_resp_once"}, req_resp, '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [N-1:0] fair_exp [5];
        bit           quiet;

        rst         = 1'b1;
        req_read    = '0;
        req_write   = '0;
        req_address = '0;
        req_wdata   = '0;
        mem_resp    = 1'b0;
        mem_rdata   = '0;
        do_reset();
        chk("rst_strobes", {mem_write, mem_read}, 2'b00);
        chk("rst_resp", req_resp, '0);
        chk("rst_addr", mem_address, '0);
        chk("rst_wdata", mem_wdata, '0);
        chk("rst_rdata", req_rdata, '0);

        // Single read; strobe one cycle after request.
        req_read[0]    = 1'b1;
        req_address[0] = 16'h1234;
        tick();
        chk("t1_latency", mem_read, 1'b1);
        serve("t1", 0, 1'b0, 16'h1234, '0, 128'h1CACE, 128'h1CACE, 3, 1);

        // mem_resp while idle must do nothing.
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
        chk("idle_resp_ign", req_resp, '0);
        tick();
        chk("idle_resp_ign2", {req_resp, mem_write, mem_read}, '0);

        // Simultaneous reads from ports 0 and 1 after reset.
        do_reset();
        req_read[0]    = 1'b1;
        req_address[0] = 16'h1234;
        req_read[1]    = 1'b1;
        req_address[1] = 16'h5678;
        serve("t2a", 0, 1'b0, 16'h1234, '0, 128'h1CACE, 128'h1CACE, 2, 1);
        serve("t2b", 1, 1'b0, 16'h5678, '0, 128'hDCACE, 128'hDCACE, 2, 1);

        // Write from port 1; read line must stay as it was.
        req_write[1]   = 1'b1;
        req_address[1] = 16'h00A0;
        req_wdata[1]   = 128'hBEEF;
        serve("t4", 1, 1'b1, 16'h00A0, 128'hBEEF, 128'h5555, 128'hDCACE, 3, 1);

        // Reset in BUSY: grant port 2 (pointer -> 3), reset, then ports 1 and 3 race.
        req_read[2]    = 1'b1;
        req_address[2] = 16'h2222;
        tick();
        chk("t5_busy", mem_read, 1'b1);
        rst         = 1'b1;
        req_read[2] = 1'b0;
        tick();
        rst = 1'b0;
        chk("t5_abort", {req_resp, mem_write, mem_read}, '0);
        chk("t5_addr_clr", mem_address, '0);
        req_read[1]    = 1'b1;
        req_address[1] = 16'h0111;
        req_read[3]    = 1'b1;
        req_address[3] = 16'h0333;
        serve("t5a", 1, 1'b0, 16'h0111, '0, 128'h11, 128'h11, 1, 1);
        serve("t5b", 3, 1'b0, 16'h0333, '0, 128'h33, 128'h33, 1, 1);

        // Withdrawn request: port 0 drops and changes its request while BUSY.
        req_read[0]    = 1'b1;
        req_address[0] = 16'h0F00;
        serve("t6", 0, 1'b0, 16'h0F00, '0, 128'h6, 128'h6, 2, 2);
        quiet = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if ({req_resp, mem_write, mem_read} !== '0) quiet = 1'b0;
        end
        chk("t6_no_regrant", quiet, 1'b1);

        // Fairness: all four ports request continuously from a fresh pointer.
        do_reset();
`ifdef ARB_FIXED_PRIORITY_EN
        fair_exp = '{0, 0, 0, 0, 0};
`else
        fair_exp = '{0, 1, 2, 3, 0};
`endif
        for (int p = 0; p < N; p++) begin
            req_read[p]    = 1'b1;
            req_address[p] = AW'(16'h1000 + p);
        end
        for (int k = 0; k < 5; k++) begin
            serve($sformatf("t3_%0d", k), int'(fair_exp[k]), 1'b0,
                  AW'(16'h1000 + fair_exp[k]), '0,
                  LW'(8'hA0 + k), LW'(8'hA0 + k), 1, 0);
        end
        req_read = '0;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
